// File: rtl/sym_err_counter.sv
// sym_err_counter: symbol/bit error counter over hold-strobed windows.
// Ports: clk, reset(n), sym_clk_en, hold, tx_sym, rx_sym, result_ack -> result bundle.
module sym_err_counter #(
  parameter int SYM_W = 2,
  parameter int CNT_W = 22
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sym_clk_en,
  input  logic             hold,
  input  logic [SYM_W-1:0] tx_sym,
  input  logic [SYM_W-1:0] rx_sym,
  input  logic             result_ack,
  output logic             result_valid,
  output logic [CNT_W-1:0] sym_count,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] bit_err_count,
  output logic             sat,
  output logic             overrun,
  output logic [7:0]       window_count
);

  typedef enum logic {IDLE, MEASURE} state_e;

  localparam logic [CNT_W-1:0] MAX = '1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] acc_sym_q, acc_sym_d;
  logic [CNT_W-1:0] acc_err_q, acc_err_d;
  logic [CNT_W-1:0] acc_bit_q, acc_bit_d;
  logic             wsat_q, wsat_d;
  logic [CNT_W-1:0] res_sym_q, res_sym_d;
  logic [CNT_W-1:0] res_err_q, res_err_d;
  logic [CNT_W-1:0] res_bit_q, res_bit_d;
  logic             sat_q, sat_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;
  logic [7:0]       wc_q, wc_d;

  logic [SYM_W-1:0] diff;
  logic [CNT_W-1:0] err_inc;
  logic [CNT_W-1:0] bit_inc;
  logic             start;
  logic             close;

  function automatic logic [CNT_W-1:0] sadd(
    input logic [CNT_W-1:0] a,
    input logic [CNT_W-1:0] b
  );
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_W] ? MAX : s[CNT_W-1:0];
  endfunction

  always_comb begin
    diff    = tx_sym ^ rx_sym;
    err_inc = CNT_W'(|diff);
    bit_inc = '0;
    for (int i = 0; i < SYM_W; i++) begin
      bit_inc = bit_inc + CNT_W'(diff[i]);
    end
  end

  // Every enabled strobe opens a window; it closes one only if one was open.
  assign start = sym_clk_en & hold;
  assign close = start & (state_q == MEASURE);

  always_comb begin
    state_d   = state_q;
    acc_sym_d = acc_sym_q;
    acc_err_d = acc_err_q;
    acc_bit_d = acc_bit_q;
    wsat_d    = wsat_q;
    res_sym_d = res_sym_q;
    res_err_d = res_err_q;
    res_bit_d = res_bit_q;
    sat_d     = sat_q;
    valid_d   = valid_q;
    ovr_d     = ovr_q;
    wc_d      = wc_q;

    if (start) begin
      state_d   = MEASURE;
      acc_sym_d = CNT_W'(1);
      acc_err_d = err_inc;
      acc_bit_d = bit_inc;
      wsat_d    = (acc_sym_d == MAX) |
                  (acc_err_d == MAX) |
                  (acc_bit_d == MAX);
    end else if (sym_clk_en && state_q == MEASURE) begin
      acc_sym_d = sadd(acc_sym_q, CNT_W'(1));
      acc_err_d = sadd(acc_err_q, err_inc);
      acc_bit_d = sadd(acc_bit_q, bit_inc);
      wsat_d    = wsat_q |
                  (acc_sym_d == MAX) |
                  (acc_err_d == MAX) |
                  (acc_bit_d == MAX);
    end

    if (close) begin
      res_sym_d = acc_sym_q;
      res_err_d = acc_err_q;
      res_bit_d = acc_bit_q;
      sat_d     = wsat_q;
      wc_d      = wc_q + 8'd1;
      valid_d   = 1'b1;
      // An ack in the closing cycle consumes the old result, so no overrun.
      if (valid_q && !result_ack) ovr_d = 1'b1;
    end else if (valid_q && result_ack) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      acc_sym_q <= '0;
      acc_err_q <= '0;
      acc_bit_q <= '0;
      wsat_q    <= 1'b0;
      res_sym_q <= '0;
      res_err_q <= '0;
      res_bit_q <= '0;
      sat_q     <= 1'b0;
      valid_q   <= 1'b0;
      ovr_q     <= 1'b0;
      wc_q      <= '0;
    end else begin
      state_q   <= state_d;
      acc_sym_q <= acc_sym_d;
      acc_err_q <= acc_err_d;
      acc_bit_q <= acc_bit_d;
      wsat_q    <= wsat_d;
      res_sym_q <= res_sym_d;
      res_err_q <= res_err_d;
      res_bit_q <= res_bit_d;
      sat_q     <= sat_d;
      valid_q   <= valid_d;
      ovr_q     <= ovr_d;
      wc_q      <= wc_d;
    end
  end

  assign result_valid  = valid_q;
  assign sym_count     = res_sym_q;
  assign err_count     = res_err_q;
  assign bit_err_count = res_bit_q;
  assign sat           = sat_q;
  assign overrun       = ovr_q;
  assign window_count  = wc_q;

endmodule

// File: tb/tb_sym_err_counter.sv
// tb_sym_err_counter: directed bench for sym_err_counter at CNT_W=22 and 4.
// Both instances share stimulus; a count-level model predicts outputs.
module tb_sym_err_counter;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0;
  logic       hold = 1'b0;
  logic [1:0] tx = '0;
  logic [1:0] rx = '0;
  logic       ack = 1'b0;

  logic        rv22, sat22, ovr22;
  logic [21:0] sc22, ec22, bc22;
  logic [7:0]  wc22;
  logic        rv4, sat4, ovr4;
  logic [3:0]  sc4, ec4, bc4;
  logic [7:0]  wc4;

  int checks = 0;
  int errors = 0;
  bit cmp_on = 1'b0;

  always #5 clk = ~clk;

  sym_err_counter u22 (
    .clk(clk), .reset(reset), .sym_clk_en(en), .hold(hold),
    .tx_sym(tx), .rx_sym(rx), .result_ack(ack),
    .result_valid(rv22), .sym_count(sc22), .err_count(ec22),
    .bit_err_count(bc22), .sat(sat22), .overrun(ovr22),
    .window_count(wc22)
  );

  sym_err_counter #(.CNT_W(4)) u4 (
    .clk(clk), .reset(reset), .sym_clk_en(en), .hold(hold),
    .tx_sym(tx), .rx_sym(rx), .result_ack(ack),
    .result_valid(rv4), .sym_count(sc4), .err_count(ec4),
    .bit_err_count(bc4), .sat(sat4), .overrun(ovr4),
    .window_count(wc4)
  );

  // Model: true (unbounded) counts; width limits applied when comparing.
  bit     meas = 1'b0;
  longint msym = 0, merr = 0, mbit = 0;
  longint rsym = 0, rerr = 0, rbit = 0;
  bit     mvalid = 1'b0, movr = 1'b0;
  int     mwc = 0;
  wire    m_close = en && hold && meas;

  function automatic longint ne(logic [1:0] t, logic [1:0] r);
    return (t != r) ? 1 : 0;
  endfunction

  function automatic longint pc(logic [1:0] t, logic [1:0] r);
    return longint'($countones(t ^ r));
  endfunction

  function automatic longint clip(longint x, int w);
    longint m;
    m = (longint'(1) << w) - 1;
    return (x > m) ? m : x;
  endfunction

  function automatic longint esat(int w);
    longint m;
    m = (longint'(1) << w) - 1;
    return (rsym >= m || rerr >= m || rbit >= m) ? 1 : 0;
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      meas <= 1'b0;
      msym <= 0; merr <= 0; mbit <= 0;
      rsym <= 0; rerr <= 0; rbit <= 0;
      mvalid <= 1'b0; movr <= 1'b0; mwc <= 0;
    end else begin
      if (m_close) begin
        rsym <= msym; rerr <= merr; rbit <= mbit;
        mwc <= (mwc + 1) % 256;
        mvalid <= 1'b1;
        if (mvalid && !ack) movr <= 1'b1;
      end else if (mvalid && ack) begin
        mvalid <= 1'b0;
      end
      if (en && hold) begin
        meas <= 1'b1;
        msym <= 1; merr <= ne(tx, rx); mbit <= pc(tx, rx);
      end else if (en && meas) begin
        msym <= msym + 1;
        merr <= merr + ne(tx, rx);
        mbit <= mbit + pc(tx, rx);
      end
    end
  end

  task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", n, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("m_valid22", 64'(rv22), 64'(mvalid));
      chk("m_sym22", 64'(sc22), clip(rsym, 22));
      chk("m_err22", 64'(ec22), clip(rerr, 22));
      chk("m_bit22", 64'(bc22), clip(rbit, 22));
      chk("m_sat22", 64'(sat22), esat(22));
      chk("m_ovr22", 64'(ovr22), 64'(movr));
      chk("m_wc22", 64'(wc22), 64'(mwc));
      chk("m_valid4", 64'(rv4), 64'(mvalid));
      chk("m_sym4", 64'(sc4), clip(rsym, 4));
      chk("m_err4", 64'(ec4), clip(rerr, 4));
      chk("m_bit4", 64'(bc4), clip(rbit, 4));
      chk("m_sat4", 64'(sat4), esat(4));
      chk("m_ovr4", 64'(ovr4), 64'(movr));
      chk("m_wc4", 64'(wc4), 64'(mwc));
    end
  end

  // One enabled symbol, then one disabled cycle with junk on the inputs.
  task automatic sym(logic [1:0] t, logic [1:0] r, logic h, logic a);
    en = 1'b1; hold = h; tx = t; rx = r; ack = a;
    @(negedge clk);
    en = 1'b0; hold = 1'($urandom_range(0, 1)); ack = 1'b0;
    tx = ~t; rx = t;
    @(negedge clk);
    hold = 1'b0;
  endtask

  task automatic clean(int n);
    for (int i = 0; i < n; i++) sym(2'(i), 2'(i), 1'b0, 1'b0);
  endtask

  task automatic ack_cyc();
    en = 1'b0; ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  task automatic rst_cyc();
    reset = 1'b0; en = 1'b1; hold = 1'b1; tx = 2'd1; rx = 2'd2;
    @(negedge clk);
    reset = 1'b1; en = 1'b0; hold = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    cmp_on = 1'b1;
    chk("rst_valid", 64'(rv22), 0);
    chk("rst_wc", 64'(wc22), 0);
    chk("rst_ovr", 64'(ovr22), 0);

    // Clean 63-symbol window.
    sym(2'd0, 2'd0, 1'b1, 1'b0);
    clean(62);
    sym(2'd3, 2'd3, 1'b1, 1'b0);
    chk("w1_sym", 64'(sc22), 63);
    chk("w1_err", 64'(ec22), 0);
    chk("w1_bit", 64'(bc22), 0);
    chk("w1_valid", 64'(rv22), 1);
    chk("w1_wc", 64'(wc22), 1);
    ack_cyc();
    chk("ack_clr", 64'(rv22), 0);
    ack_cyc();
    chk("ack_idle", 64'(rv22), 0);

    // 5 double-bit and 3 single-bit errors.
    for (int i = 1; i <= 62; i++) begin
      if (i <= 5)      sym(2'(i), 2'(i) ^ 2'b11, 1'b0, 1'b0);
      else if (i <= 8) sym(2'(i), 2'(i) ^ 2'b01, 1'b0, 1'b0);
      else             sym(2'(i), 2'(i), 1'b0, 1'b0);
    end
    sym(2'd2, 2'd2, 1'b1, 1'b0);
    chk("w2_sym", 64'(sc22), 63);
    chk("w2_err", 64'(ec22), 8);
    chk("w2_bit", 64'(bc22), 13);
    chk("w2_ovr", 64'(ovr22), 0);

    // Close again without ack: overrun.
    clean(9);
    sym(2'd1, 2'd1, 1'b1, 1'b0);
    chk("w3_sym", 64'(sc22), 10);
    chk("w3_valid", 64'(rv22), 1);
    chk("w3_ovr", 64'(ovr22), 1);

    // Close coinciding with ack: no overrun.
    rst_cyc();
    chk("r2_ovr", 64'(ovr22), 0);
    sym(2'd0, 2'd0, 1'b1, 1'b0);
    clean(4);
    sym(2'd0, 2'd0, 1'b1, 1'b0);
    clean(6);
    sym(2'd0, 2'd0, 1'b1, 1'b1);
    chk("ca_sym", 64'(sc22), 7);
    chk("ca_valid", 64'(rv22), 1);
    chk("ca_ovr", 64'(ovr22), 0);
    ack_cyc();

    // 20 wrong symbols: saturates the 4-bit instance only.
    clean(3);
    sym(2'd1, 2'd2, 1'b1, 1'b0);
    for (int i = 0; i < 19; i++) sym(2'(i), 2'(i) ^ 2'b11, 1'b0, 1'b0);
    sym(2'd0, 2'd0, 1'b1, 1'b0);
    chk("s4_sym", 64'(sc4), 15);
    chk("s4_err", 64'(ec4), 15);
    chk("s4_sat", 64'(sat4), 1);
    chk("s22_sym", 64'(sc22), 20);
    chk("s22_bit", 64'(bc22), 40);
    chk("s22_sat", 64'(sat22), 0);
    ack_cyc();
    clean(9);
    sym(2'd0, 2'd0, 1'b1, 1'b0);
    chk("c4_sym", 64'(sc4), 10);
    chk("c4_err", 64'(ec4), 0);
    chk("c4_sat", 64'(sat4), 0);

    // Enable low for 100 clocks with hold toggling.
    clean(3);
    for (int i = 0; i < 100; i++) begin
      en = 1'b0; hold = (i % 3 == 0); tx = 2'(i); rx = ~2'(i);
      @(negedge clk);
    end
    hold = 1'b0;
    chk("en0_sym", 64'(sc4), 10);
    chk("en0_valid", 64'(rv4), 1);
    sym(2'd1, 2'd0, 1'b0, 1'b0);
    sym(2'd2, 2'd0, 1'b0, 1'b0);
    sym(2'd0, 2'd0, 1'b1, 1'b0);
    chk("en0_wsym", 64'(sc22), 6);
    chk("en0_werr", 64'(ec22), 2);

    // Reset mid-window.
    clean(5);
    rst_cyc();
    chk("mr_valid", 64'(rv22), 0);
    chk("mr_sym", 64'(sc22), 0);
    chk("mr_ovr", 64'(ovr22), 0);
    chk("mr_wc", 64'(wc4), 0);
    sym(2'd0, 2'd0, 1'b1, 1'b0);
    chk("mr_start", 64'(rv22), 0);
    clean(4);
    sym(2'd0, 2'd0, 1'b1, 1'b0);
    chk("mr_sym5", 64'(sc22), 5);
    chk("mr_wc1", 64'(wc22), 1);

    // window_count wrap.
    for (int i = 0; i < 254; i++) sym(2'd0, 2'd0, 1'b1, 1'b1);
    chk("wc_255", 64'(wc22), 255);
    sym(2'd0, 2'd0, 1'b1, 1'b1);
    chk("wc_wrap", 64'(wc22), 0);
    chk("wc_sym1", 64'(sc22), 1);

    cmp_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
